// File: rtl/ex_trap_ctrl_if.sv
// ICB slave port bundle for the external-trap controller.
interface ex_trap_ctrl_if;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic [31:0] icb_cmd_addr;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic        icb_rsp_err;
  logic [31:0] icb_rsp_rdata;

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read,
    output icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err,
    input  icb_rsp_rdata
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read,
    input  icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_err,
    output icb_rsp_rdata
  );
endinterface

// File: rtl/ex_trap_ctrl.sv
// External interrupt aggregator: 32 synced IRQ lines, edge/level
// pending bits, lowest-index arbitration onto the core trap handshake.
module ex_trap_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int REG_AW      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] irq_i,
  ex_trap_ctrl_if.slave icb,
  output logic        core_ex_trap_valid_o,
  output logic [4:0]  core_ex_trap_id_o,
  input  logic        core_ex_trap_ready_i
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0][31:0] sync_q;
  logic [31:0] s, p_q;
  logic [31:0] pend_q, pend_d;
  logic [31:0] enable_q, edge_q;
  logic [31:0] act, acc_clr, w1c, bmask;
  logic [4:0]  id_q, id_d, first;

  logic [REG_AW-1:0] off;
  logic hs, wr, aligned;
  logic sel_pend, sel_en, sel_edge, sel_stat;
  logic [31:0] rd, status;
  logic        rd_err;
  logic unused_addr;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      p_q    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
      p_q    <= s;
    end
  end

  assign off         = icb.icb_cmd_addr[REG_AW-1:0];
  assign unused_addr = ^icb.icb_cmd_addr[31:REG_AW];
  assign aligned     = off[1:0] == 2'b00;
  assign sel_pend    = aligned & (off == REG_AW'(8'h00));
  assign sel_en      = aligned & (off == REG_AW'(8'h04));
  assign sel_edge    = aligned & (off == REG_AW'(8'h08));
  assign sel_stat    = aligned & (off == REG_AW'(8'h0C));

  assign icb.icb_cmd_ready = ~icb.icb_rsp_valid | icb.icb_rsp_ready;
  assign hs = icb.icb_cmd_valid & icb.icb_cmd_ready;
  assign wr = hs & ~icb.icb_cmd_read;

  assign bmask = {{8{icb.icb_cmd_wmask[3]}}, {8{icb.icb_cmd_wmask[2]}},
                  {8{icb.icb_cmd_wmask[1]}}, {8{icb.icb_cmd_wmask[0]}}};
  assign w1c = (wr & sel_pend) ? (bmask & icb.icb_cmd_wdata) : '0;

  // Edge bits: new edge beats any clear; level bits just mirror the line.
  assign pend_d = (edge_q & ((pend_q & ~w1c & ~acc_clr) | (s & ~p_q)))
                | (~edge_q & s);

  assign core_ex_trap_valid_o = (state_q == REQ);
  assign core_ex_trap_id_o    = id_q;
  assign status = {23'b0, core_ex_trap_valid_o, 3'b0, id_q};

  always_comb begin
    rd     = '0;
    rd_err = 1'b0;
    unique case (1'b1)
      sel_pend: rd = pend_q;
      sel_en:   rd = enable_q;
      sel_edge: rd = edge_q;
      sel_stat: rd = status;
      default:  rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      enable_q <= '0;
      edge_q   <= '0;
    end else begin
      pend_q <= pend_d;
      if (wr & sel_en)
        enable_q <= (enable_q & ~bmask) | (icb.icb_cmd_wdata & bmask);
      if (wr & sel_edge)
        edge_q <= (edge_q & ~bmask) | (icb.icb_cmd_wdata & bmask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icb.icb_rsp_valid <= 1'b0;
      icb.icb_rsp_err   <= 1'b0;
      icb.icb_rsp_rdata <= '0;
    end else if (hs) begin
      icb.icb_rsp_valid <= 1'b1;
      icb.icb_rsp_err   <= rd_err;
      icb.icb_rsp_rdata <= icb.icb_cmd_read ? rd : '0;
    end else if (icb.icb_rsp_ready) begin
      icb.icb_rsp_valid <= 1'b0;
    end
  end

  assign act = pend_q & enable_q;

  always_comb begin
    first = '0;
    for (int i = 31; i >= 0; i--)
      if (act[i]) first = 5'(i);
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    acc_clr = '0;
    unique case (state_q)
      IDLE: if (|act) begin
        id_d    = first;
        state_d = REQ;
      end
      REQ: if (core_ex_trap_ready_i) begin
        acc_clr = 32'(edge_q[id_q]) << id_q;
        state_d = GAP;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

endmodule

// File: tb/tb_ex_trap_ctrl.sv
// Directed bench for ex_trap_ctrl: latency, priority, level re-issue,
// no pre-emption, ICB decode/stall, W1C races and mid-request reset.
module tb_ex_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] irq;
  logic        valid;
  logic [4:0]  id;
  logic        ready;

  int n_checks = 0;
  int n_fail   = 0;

  ex_trap_ctrl_if bus ();

  ex_trap_ctrl #(.SYNC_STAGES(2), .REG_AW(8)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .irq_i                (irq),
    .icb                  (bus.slave),
    .core_ex_trap_valid_o (valid),
    .core_ex_trap_id_o    (id),
    .core_ex_trap_ready_i (ready)
  );

  always #5 clk = ~clk;

  task automatic icb_read(input logic [31:0] a, output logic [31:0] d,
                          output logic e, output logic ok);
    @(negedge clk);
    bus.icb_cmd_valid = 1'b1;
    bus.icb_cmd_addr  = a;
    bus.icb_cmd_read  = 1'b1;
    bus.icb_cmd_wmask = 4'h0;
    bus.icb_rsp_ready = 1'b1;
    @(negedge clk);
    bus.icb_cmd_valid = 1'b0;
    ok = bus.icb_rsp_valid;
    d  = bus.icb_rsp_rdata;
    e  = bus.icb_rsp_err;
  endtask

  task automatic icb_write(input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] m, output logic e);
    @(negedge clk);
    bus.icb_cmd_valid = 1'b1;
    bus.icb_cmd_addr  = a;
    bus.icb_cmd_read  = 1'b0;
    bus.icb_cmd_wdata = wd;
    bus.icb_cmd_wmask = m;
    bus.icb_rsp_ready = 1'b1;
    @(negedge clk);
    bus.icb_cmd_valid = 1'b0;
    e = bus.icb_rsp_err;
  endtask

  task automatic wait_valid(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic accept();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic e, ok;
    rst_n = 1'b0;
    irq = '0;
    ready = 1'b0;
    bus.icb_cmd_valid = 1'b0;
    bus.icb_cmd_addr  = '0;
    bus.icb_cmd_read  = 1'b0;
    bus.icb_cmd_wdata = '0;
    bus.icb_cmd_wmask = '0;
    bus.icb_rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({valid, id, bus.icb_rsp_valid, bus.icb_rsp_err} !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_out: got %b expected 0",
               {valid, id, bus.icb_rsp_valid, bus.icb_rsp_err});
    end
    n_checks++;
    if (bus.icb_rsp_rdata !== 32'h0 || bus.icb_cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rsp: rdata %h rdy %b expected 0/1",
               bus.icb_rsp_rdata, bus.icb_cmd_ready);
    end
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      icb_read(32'(r * 4), d, e, ok);
      n_checks++;
      if (!ok || e !== 1'b0 || d !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h err %b ok %b expected 0",
                 r, d, e, ok);
      end
    end
  endtask

  task automatic test_edge_latency();
    logic [31:0] d;
    logic e, ok;
    icb_write(32'h04, 32'h1, 4'hF, e);
    icb_write(32'h08, 32'h1, 4'hF, e);
    irq[0] = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_early: valid %b expected 0", valid);
    end
    irq[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b1 || id !== 5'd0) begin
      n_fail++;
      $display("FAIL lat_valid: valid %b id %0d expected 1/0", valid, id);
    end
    icb_read(32'h0C, d, e, ok);
    n_checks++;
    if (d !== 32'h100) begin
      n_fail++;
      $display("FAIL status_req: got %h expected 00000100", d);
    end
    accept();
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_drop: valid %b expected 0", valid);
    end
    icb_read(32'h00, d, e, ok);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL lat_pend: got %h expected 0", d);
    end
  endtask

  task automatic test_priority();
    logic e, ok;
    icb_write(32'h04, 32'h88, 4'hF, e);
    icb_write(32'h08, 32'h88, 4'hF, e);
    irq[3] = 1'b1;
    irq[7] = 1'b1;
    wait_valid(ok);
    n_checks++;
    if (!ok || id !== 5'd3) begin
      n_fail++;
      $display("FAIL prio_first: ok %b id %0d expected 1/3", ok, id);
    end
    irq[3] = 1'b0;
    irq[7] = 1'b0;
    accept();
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_gap: valid %b expected 0", valid);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (valid !== 1'b1 || id !== 5'd7) begin
      n_fail++;
      $display("FAIL prio_second: valid %b id %0d expected 1/7", valid, id);
    end
    accept();
    repeat (5) @(negedge clk);
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_idle: valid %b expected 0", valid);
    end
  endtask

  task automatic test_level();
    logic e, ok;
    icb_write(32'h08, 32'h0, 4'hF, e);
    icb_write(32'h04, 32'h20, 4'hF, e);
    irq[5] = 1'b1;
    wait_valid(ok);
    n_checks++;
    if (!ok || id !== 5'd5) begin
      n_fail++;
      $display("FAIL lvl_first: ok %b id %0d expected 1/5", ok, id);
    end
    accept();
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lvl_gap: valid %b expected 0", valid);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (valid !== 1'b1 || id !== 5'd5) begin
      n_fail++;
      $display("FAIL lvl_reissue: valid %b id %0d expected 1/5", valid, id);
    end
    irq[5] = 1'b0;
    repeat (4) @(negedge clk);
    accept();
    repeat (5) @(negedge clk);
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lvl_quiet: valid %b expected 0", valid);
    end
  endtask

  task automatic test_no_preempt();
    logic [31:0] d;
    logic e, ok;
    icb_write(32'h04, 32'h204, 4'hF, e);
    icb_write(32'h08, 32'h204, 4'hF, e);
    irq[9] = 1'b1;
    wait_valid(ok);
    n_checks++;
    if (!ok || id !== 5'd9) begin
      n_fail++;
      $display("FAIL npe_first: ok %b id %0d expected 1/9", ok, id);
    end
    irq[2] = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (valid !== 1'b1 || id !== 5'd9) begin
      n_fail++;
      $display("FAIL npe_hold: valid %b id %0d expected 1/9", valid, id);
    end
    icb_read(32'h0C, d, e, ok);
    n_checks++;
    if (d !== 32'h109) begin
      n_fail++;
      $display("FAIL npe_status: got %h expected 00000109", d);
    end
    accept();
    wait_valid(ok);
    n_checks++;
    if (!ok || id !== 5'd2) begin
      n_fail++;
      $display("FAIL npe_next: ok %b id %0d expected 1/2", ok, id);
    end
    irq[2] = 1'b0;
    irq[9] = 1'b0;
    accept();
  endtask

  task automatic test_icb();
    logic [31:0] d;
    logic e, ok;
    icb_read(32'h10, d, e, ok);
    n_checks++;
    if (!ok || e !== 1'b1 || d !== 32'h0) begin
      n_fail++;
      $display("FAIL bad_off: rdata %h err %b expected 0/1", d, e);
    end
    icb_read(32'h05, d, e, ok);
    n_checks++;
    if (e !== 1'b1 || d !== 32'h0) begin
      n_fail++;
      $display("FAIL misalign: rdata %h err %b expected 0/1", d, e);
    end
    icb_write(32'h0C, 32'hFFFF_FFFF, 4'hF, e);
    n_checks++;
    if (e !== 1'b0) begin
      n_fail++;
      $display("FAIL stat_wr: err %b expected 0", e);
    end
    icb_write(32'h10, 32'hFFFF_FFFF, 4'hF, e);
    n_checks++;
    if (e !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_wr: err %b expected 1", e);
    end
    icb_write(32'h04, 32'h0, 4'hF, e);
    icb_write(32'h04, 32'hFFFF_FFFF, 4'h2, e);
    icb_read(32'h04, d, e, ok);
    n_checks++;
    if (d !== 32'h0000_FF00) begin
      n_fail++;
      $display("FAIL wmask: got %h expected 0000ff00", d);
    end
    @(negedge clk);
    bus.icb_cmd_valid = 1'b1;
    bus.icb_cmd_addr  = 32'h04;
    bus.icb_cmd_read  = 1'b1;
    bus.icb_rsp_ready = 1'b0;
    @(negedge clk);
    bus.icb_cmd_addr = 32'h08;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (bus.icb_rsp_valid !== 1'b1 || bus.icb_cmd_ready !== 1'b0 ||
          bus.icb_rsp_rdata !== 32'h0000_FF00 || bus.icb_rsp_err !== 1'b0) begin
        n_fail++;
        $display("FAIL stall%0d: v %b crdy %b rdata %h err %b expected 1/0/0000ff00/0",
                 k, bus.icb_rsp_valid, bus.icb_cmd_ready,
                 bus.icb_rsp_rdata, bus.icb_rsp_err);
      end
      @(negedge clk);
    end
    bus.icb_rsp_ready = 1'b1;
    @(negedge clk);
    bus.icb_cmd_valid = 1'b0;
    n_checks++;
    if (bus.icb_rsp_valid !== 1'b1 || bus.icb_rsp_rdata !== 32'h204) begin
      n_fail++;
      $display("FAIL stall_release: v %b rdata %h expected 1/00000204",
               bus.icb_rsp_valid, bus.icb_rsp_rdata);
    end
  endtask

  task automatic test_race_reset();
    logic [31:0] d;
    logic e, ok;
    icb_write(32'h04, 32'h0, 4'hF, e);
    icb_write(32'h08, 32'h10, 4'hF, e);
    @(negedge clk);
    irq[4] = 1'b1;
    repeat (2) @(negedge clk);
    bus.icb_cmd_valid = 1'b1;
    bus.icb_cmd_addr  = 32'h00;
    bus.icb_cmd_read  = 1'b0;
    bus.icb_cmd_wdata = 32'h10;
    bus.icb_cmd_wmask = 4'hF;
    @(negedge clk);
    bus.icb_cmd_valid = 1'b0;
    icb_read(32'h00, d, e, ok);
    n_checks++;
    if (d !== 32'h10) begin
      n_fail++;
      $display("FAIL set_vs_w1c: got %h expected 00000010", d);
    end
    icb_write(32'h00, 32'h10, 4'h1, e);
    icb_read(32'h00, d, e, ok);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL w1c: got %h expected 0", d);
    end
    irq[4] = 1'b0;
    icb_write(32'h04, 32'h10, 4'hF, e);
    irq[4] = 1'b1;
    wait_valid(ok);
    n_checks++;
    if (!ok || id !== 5'd4) begin
      n_fail++;
      $display("FAIL rst_req: ok %b id %0d expected 1/4", ok, id);
    end
    irq[4] = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (valid !== 1'b0 || id !== 5'd0 || bus.icb_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: valid %b id %0d rspv %b expected 0/0/0",
               valid, id, bus.icb_rsp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      icb_read(32'(r * 4), d, e, ok);
      n_checks++;
      if (!ok || d !== 32'h0) begin
        n_fail++;
        $display("FAIL rst_reg%0d: got %h ok %b expected 0", r, d, ok);
      end
    end
  endtask

  initial begin
    test_reset();
    test_edge_latency();
    test_priority();
    test_level();
    test_no_preempt();
    test_icb();
    test_race_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_trap_ctrl.md
Name: ex_trap_ctrl

Overview:
- External-interrupt aggregator that drives the core's external-trap handshake (core_ex_trap_valid/id/ready).
- It synchronises 32 asynchronous IRQ lines and latches each as an edge or level pending bit.
- It offers the lowest-numbered enabled pending source to the core.
- Software configures it as an ICB slave in the s3 slot of the 2-master/8-slave bridge.

Parameters:
SYNC_STAGES, 2, synchroniser flop depth per IRQ line (legal values 2..4)
REG_AW, 8, number of low ICB address bits decoded for the register offset

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active-low
irq_i  input  32  external interrupt lines, asynchronous, active-high
icb_cmd_valid  input  1  ICB command valid
icb_cmd_ready  output  1  ICB command ready
icb_cmd_addr  input  32  byte address; only [REG_AW-1:0] decoded
icb_cmd_read  input  1  1=read, 0=write
icb_cmd_wdata  input  32  write data
icb_cmd_wmask  input  4  byte write enables
icb_rsp_valid  output  1  response valid
icb_rsp_ready  input  1  response ready
icb_rsp_err  output  1  response error
icb_rsp_rdata  output  32  read data
core_ex_trap_valid_o  output  1  trap request to core
core_ex_trap_id_o  output  5  trap source ID
core_ex_trap_ready_i  input  1  core accepts trap

Behaviour:
Reset values:
- Clock is clk; reset is rst_n, asynchronous, active-low.
- Reset clears all registers, synchronisers, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata, core_ex_trap_valid_o and core_ex_trap_id_o to 0.

Input capture:
- Each irq_i[n] passes through SYNC_STAGES flops. s[n] is the last stage; p[n] is s[n] delayed by one flop.
- EDGE[n]=1: pending bit PEND[n] is set when s[n]&~p[n], and stays set until cleared.
- EDGE[n]=0: PEND[n] follows s[n] every cycle and is not writable.
- Latency: an irq_i rise reaches PEND after SYNC_STAGES+1 cycles; core_ex_trap_valid_o rises 1 cycle later if the controller is IDLE.

Register map (offset = addr[REG_AW-1:0], word aligned):
- 0x00 PEND: read returns PEND. Write-1-to-clear, edge bits only, under wmask bytes.
- 0x04 ENABLE: RW, byte-masked.
- 0x08 EDGE: RW, byte-masked.
- 0x0C STATUS: RO. [4:0]=current/last issued ID, [8]=core_ex_trap_valid_o, [31:9]=0.
- Any other offset, or addr[1:0]!=0: rsp_err=1, rdata=0, no write effect.
- Writes to STATUS: ignored, rsp_err=0.

ICB timing:
- icb_cmd_ready = ~icb_rsp_valid | icb_rsp_ready (combinational).
- A command handshake registers the response; icb_rsp_valid rises the next cycle.
- Write effects take place at the handshake clock edge.
- rsp_rdata and rsp_err stay stable while rsp_valid & ~rsp_ready.
- Back-to-back commands give one response per cycle when rsp_ready=1.

Trap FSM:
- IDLE: if any (PEND & ENABLE) bit is set, latch id = lowest set index, assert valid, go to REQ.
- REQ: valid=1 and id held stable until core_ex_trap_ready_i=1. No pre-emption: a higher-priority arrival or disabling the source does not change the offered id.
- On ready in REQ: clear PEND[id] if EDGE[id]=1, drop valid, go to GAP.
- GAP: one cycle with valid=0, so a level PEND settles, then go to IDLE.
- ready_i is ignored outside REQ.
- A level source that is still high re-issues after GAP; clearing it is software's job.

Simultaneous events, same cycle and same bit:
- Edge set and W1C: set wins.
- Edge set and trap-accept clear: set wins.
- W1C and accept clear: bit cleared.
- EDGE bit changed while the line is pending: the new mode applies from the next cycle; PEND keeps its current value.

Reset mid-operation:
- Valid and rsp_valid drop immediately.
- An outstanding ICB response is lost.
- The FSM returns to IDLE.

Test Plan:
1. Reset; write ENABLE=0x0000_0001, EDGE=0x1; pulse irq_i[0] high for 3 cycles -> PEND[0]=1 after 3 cycles; valid=1, id=0 at cycle 4; ready=1 -> valid=0, PEND read back 0x0.
2. Enable sources 3 and 7 as edge; raise both in the same cycle -> id=3 first; after ready, then GAP, id=7 is offered.
3. Source 5 level, enabled, irq_i[5] held high; accept with ready -> valid drops for the GAP cycle, then re-asserts with id=5; deassert the line -> no further request.
4. With valid=1, id=9 and ready=0, raise enabled source 2 -> id stays 9 until ready; source 2 is issued next.
5. Read offset 0x10 -> rsp_err=1, rdata=0. Write wmask=0x2, wdata=0xFFFF_FFFF to ENABLE -> ENABLE=0x0000_FF00. Hold rsp_ready=0 -> cmd_ready=0 and rsp is stable.
6. Edge pulse on source 4 in the same cycle as a W1C of bit 4 -> PEND[4]=1. Assert rst_n=0 while in REQ -> valid=0 and all registers read 0 after release.
